// File: rtl/parametrik_medyan_birimi.sv
// Streaming median of non-overlapping PENCERE-sample windows, using a descending top-TUT insertion array.
// Optional MEDYAN_MINMAKS_EN adds registered window minimum (enk_o) and maximum (enb_o) outputs.
module parametrik_medyan_birimi #(
    parameter int PIXEL_BIT = 8,
    parameter int PENCERE   = 9
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 temizle_i,
    input  logic                 sayi_gecerli_i,
    input  logic [PIXEL_BIT-1:0] sayi_i,
    output logic                 sayi_hazir_o,
    output logic                 medyan_gecerli_o,
    input  logic                 medyan_hazir_i,
`ifdef MEDYAN_MINMAKS_EN
    output logic [PIXEL_BIT-1:0] enk_o,
    output logic [PIXEL_BIT-1:0] enb_o,
`endif
    output logic [PIXEL_BIT-1:0] medyan_o
);
    localparam int TUT       = (PENCERE + 1) / 2;
    localparam int SAYAC_BIT = $clog2(PENCERE);
    localparam logic [SAYAC_BIT-1:0] SON = SAYAC_BIT'(PENCERE - 1);

    logic [PIXEL_BIT-1:0] dizi_q [TUT];
    logic [PIXEL_BIT-1:0] dizi_d [TUT];
    logic [TUT-1:0]       buyuk;
    logic [SAYAC_BIT-1:0] sayac_q;
    logic [PIXEL_BIT-1:0] medyan_q;
    logic                 medyan_gecerli_q;
    logic                 kabul;
    logic                 son_ornek;

    // Stall only when the completing sample would overwrite an unconsumed result.
    assign sayi_hazir_o = !(sayac_q == SON && medyan_gecerli_q && !medyan_hazir_i);
    assign kabul        = sayi_gecerli_i && sayi_hazir_o;
    assign son_ornek    = kabul && !temizle_i && (sayac_q == SON);

    // buyuk is monotonic over the descending array: the first set bit marks the insertion slot.
    for (genvar g = 0; g < TUT; g++) begin : g_ekle
        assign buyuk[g] = sayi_i > dizi_q[g];
        if (g == 0) begin : g_ilk
            assign dizi_d[g] = buyuk[g] ? sayi_i : dizi_q[g];
        end else begin : g_diger
            assign dizi_d[g] = !buyuk[g] ? dizi_q[g] : (buyuk[g-1] ? dizi_q[g-1] : sayi_i);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < TUT; i++) dizi_q[i] <= '0;
            sayac_q <= '0;
        end else if (temizle_i || son_ornek) begin
            for (int i = 0; i < TUT; i++) dizi_q[i] <= '0;
            sayac_q <= '0;
        end else if (kabul) begin
            for (int i = 0; i < TUT; i++) dizi_q[i] <= dizi_d[i];
            sayac_q <= sayac_q + SAYAC_BIT'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            medyan_q         <= '0;
            medyan_gecerli_q <= 1'b0;
        end else if (son_ornek) begin
            medyan_q         <= dizi_d[TUT-1];
            medyan_gecerli_q <= 1'b1;
        end else if (medyan_hazir_i) begin
            medyan_gecerli_q <= 1'b0;
        end
    end

    assign medyan_o         = medyan_q;
    assign medyan_gecerli_o = medyan_gecerli_q;

`ifdef MEDYAN_MINMAKS_EN
    logic [PIXEL_BIT-1:0] min_q;
    logic [PIXEL_BIT-1:0] min_d;
    logic [PIXEL_BIT-1:0] enk_q;
    logic [PIXEL_BIT-1:0] enb_q;

    assign min_d = (sayi_i < min_q) ? sayi_i : min_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            min_q <= '1;
            enk_q <= '0;
            enb_q <= '0;
        end else begin
            if (temizle_i || son_ornek) begin
                min_q <= '1;
            end else if (kabul) begin
                min_q <= min_d;
            end
            if (son_ornek) begin
                enk_q <= min_d;
                enb_q <= dizi_d[0];
            end
        end
    end

    assign enk_o = enk_q;
    assign enb_o = enb_q;
`endif
endmodule
